// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_WAIT = 2'd1,
        IF_DROP = 2'd2,
        IF_FULL = 2'd3
    } if_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Instructions are word aligned; low address bits are ignored on redirect.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats freeze, freeze beats a new load,
// and anything else inserts a bubble with the pc held.
module if_fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        freeze,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!freeze) begin
            if (load) begin
                pc_d    = load_pc;
                instr_d = load_instr;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign if_pc          = pc_q;
    assign if_instruction = instr_q;
    assign if_valid       = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem req/ack handshake and feeds
// the IF/ID register, with a one-word buffer to absorb decode freezes.
//
//   state   | meaning
//   IF_IDLE | just out of reset, no request yet
//   IF_WAIT | request to fetch_pc outstanding
//   IF_DROP | redirected while a request was in flight; its word is discarded
//   IF_FULL | word fetched during a freeze, held in the buffer
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid
);

    if_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic [31:0] pc_next;
    logic [31:0] br_target;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    assign pc_next   = fetch_pc_q + PC_STEP;
    assign br_target = align_pc(branch_addr);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        drop_addr_d   = drop_addr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc_d      = buf_pc_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = pc_next;

        case (state_q)
            IF_IDLE: begin
                state_d = IF_WAIT;
                if (branch_taken) fetch_pc_d = br_target;
            end
            IF_WAIT: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        fetch_pc_d = br_target;
                    end else begin
                        fetch_pc_d = pc_next;
                        if (freeze) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_next;
                            state_d     = IF_FULL;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end else if (branch_taken) begin
                    // The in-flight request cannot be withdrawn; keep its address on the bus.
                    drop_addr_d = fetch_pc_q;
                    fetch_pc_d  = br_target;
                    state_d     = IF_DROP;
                end
            end
            IF_DROP: begin
                if (branch_taken) fetch_pc_d = br_target;
                if (imem_ack) state_d = IF_WAIT;
            end
            IF_FULL: begin
                if (branch_taken) begin
                    fetch_pc_d = br_target;
                    state_d    = IF_WAIT;
                end else if (!freeze) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr_q;
                    deliver_pc    = buf_pc_q;
                    state_d       = IF_WAIT;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IF_IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

    assign imem_req  = (state_q == IF_WAIT) || (state_q == IF_DROP);
    assign imem_addr = (state_q == IF_DROP) ? drop_addr_q : fetch_pc_q;

    if_fetch_stage_if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .rst           (rst),
        .flush         (branch_taken),
        .freeze        (freeze),
        .load          (deliver),
        .load_pc       (deliver_pc),
        .load_instr    (deliver_instr),
        .if_pc         (if_pc),
        .if_instruction(if_instruction),
        .if_valid      (if_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed cycle table, then random traffic against
// a fetch-order reference model.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_addr   (branch_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_pc         (if_pc),
        .if_instruction(if_instruction),
        .if_valid      (if_valid)
    );

    // Memory content: unique per word address and never equal to NOP.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_1235;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fz;
        logic        br;
        logic [31:0] baddr;
        logic        ack;
        logic [31:0] ack_addr;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic fz, input logic br, input logic [31:0] ba,
                       input logic ak, input logic [31:0] aa, input logic er,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.fz = fz; v.br = br; v.baddr = ba; v.ack = ak; v.ack_addr = aa;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        tv.push_back(v);
    endtask

    // reference model / memory responder state
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] fetch_next;
    logic        stale;
    logic        held;
    logic [31:0] held_addr;
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          delivered;
    logic        fz, br, got;
    logic [31:0] baddr, gaddr;

    task automatic model_deliver(input logic [31:0] a);
        m_valid = 1'b1;
        m_pc    = a + 32'd4;
        m_instr = word_of(a);
        delivered++;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   imem_req,       32'd0);
        check("rst_valid", if_valid,       32'd0);
        check("rst_pc",    if_pc,          32'd0);
        check("rst_instr", if_instruction, NOP);

        // ---------------- directed table ----------------
        //   rst fz br baddr          ack addr           req addr           v pc
        add(0, 0, 0, 0,             0, 0,             1, 32'h0,          0, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, 32'h0,          0, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, 32'h0,          0, 32'h0);
        add(0, 0, 0, 0,             1, 32'h0,         1, 32'h4,          1, 32'h4);
        add(0, 0, 0, 0,             0, 0,             1, 32'h4,          0, 32'h4);
        add(0, 0, 0, 0,             0, 0,             1, 32'h4,          0, 32'h4);
        add(0, 0, 0, 0,             1, 32'h4,         1, 32'h8,          1, 32'h8);
        add(0, 1, 0, 0,             0, 0,             1, 32'h8,          1, 32'h8);
        add(0, 1, 0, 0,             0, 0,             1, 32'h8,          1, 32'h8);
        add(0, 1, 0, 0,             1, 32'h8,         0, 32'h0,          1, 32'h8);
        add(0, 0, 0, 0,             0, 0,             1, 32'hC,          1, 32'hC);
        add(0, 0, 0, 0,             0, 0,             1, 32'hC,          0, 32'hC);
        add(0, 0, 0, 0,             0, 0,             1, 32'hC,          0, 32'hC);
        add(0, 0, 0, 0,             1, 32'hC,         1, 32'h10,         1, 32'h10);
        add(0, 0, 0, 0,             0, 0,             1, 32'h10,         0, 32'h10);
        add(0, 0, 1, 32'h100,       0, 0,             1, 32'h10,         0, 32'h10);
        add(0, 0, 0, 0,             0, 0,             1, 32'h10,         0, 32'h10);
        add(0, 0, 0, 0,             1, 32'h10,        1, 32'h100,        0, 32'h10);
        add(0, 0, 0, 0,             0, 0,             1, 32'h100,        0, 32'h10);
        add(0, 0, 0, 0,             0, 0,             1, 32'h100,        0, 32'h10);
        add(0, 0, 0, 0,             1, 32'h100,       1, 32'h104,        1, 32'h104);
        add(0, 0, 0, 0,             0, 0,             1, 32'h104,        0, 32'h104);
        add(0, 0, 0, 0,             0, 0,             1, 32'h104,        0, 32'h104);
        add(0, 1, 1, 32'h200,       1, 32'h104,       1, 32'h200,        0, 32'h104);
        add(0, 0, 1, 32'hFFFF_FFFE, 0, 0,             1, 32'h200,        0, 32'h104);
        add(0, 0, 0, 0,             1, 32'h200,       1, 32'hFFFF_FFFC,  0, 32'h104);
        add(0, 0, 0, 0,             0, 0,             1, 32'hFFFF_FFFC,  0, 32'h104);
        add(0, 0, 0, 0,             0, 0,             1, 32'hFFFF_FFFC,  0, 32'h104);
        add(0, 0, 0, 0,             1, 32'hFFFF_FFFC, 1, 32'h0,          1, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, 32'h0,          0, 32'h0);
        add(1, 0, 0, 0,             1, 32'h0,         0, 32'h0,          0, 32'h0);
        add(1, 0, 0, 0,             1, 32'h0,         0, 32'h0,          0, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, RST_PC,         0, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, RST_PC,         0, 32'h0);
        add(0, 0, 0, 0,             0, 0,             1, RST_PC,         0, 32'h0);
        add(0, 0, 0, 0,             1, RST_PC,        1, RST_PC + 32'd4, 1, RST_PC + 32'd4);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst          = tv[i].rst;
            freeze       = tv[i].fz;
            branch_taken = tv[i].br;
            branch_addr  = tv[i].baddr;
            imem_ack     = tv[i].ack;
            imem_rdata   = tv[i].ack ? word_of(tv[i].ack_addr) : 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            check($sformatf("row%0d_req", i), imem_req, tv[i].exp_req);
            if (tv[i].exp_req) check($sformatf("row%0d_addr", i), imem_addr, tv[i].exp_addr);
            check($sformatf("row%0d_valid", i), if_valid, tv[i].exp_valid);
            check($sformatf("row%0d_pc", i), if_pc, tv[i].exp_pc);
            check($sformatf("row%0d_instr", i), if_instruction,
                  tv[i].exp_valid ? word_of(tv[i].exp_pc - 32'd4) : NOP);
        end

        // ---------------- random traffic vs reference model ----------------
        @(negedge clk);
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP;
        fetch_next = RST_PC; stale = 1'b0; held = 1'b0; held_addr = 32'h0;
        mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0; delivered = 0;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            if (mem_busy) begin
                check("req_held", imem_req, 32'd1);
                check("addr_stable", imem_addr, mem_addr);
                if (mem_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = word_of(mem_addr);
                    mem_busy   = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if (imem_req) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = $urandom_range(0, 3);
            end

            fz    = ($urandom_range(0, 3) == 0);
            br    = ($urandom_range(0, 11) == 0);
            baddr = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF5 : $urandom;
            freeze       = fz;
            branch_taken = br;
            branch_addr  = baddr;

            if (br) begin
                m_valid = 1'b0;
                m_instr = NOP;
                held    = 1'b0;
                if (imem_ack) stale = 1'b0;
                else if (mem_busy) stale = 1'b1;
                fetch_next = baddr & ~32'h3;
            end else begin
                got = 1'b0;
                gaddr = 32'h0;
                if (imem_ack) begin
                    if (stale) begin
                        stale = 1'b0;
                    end else begin
                        got = 1'b1;
                        gaddr = fetch_next;
                        fetch_next = fetch_next + 32'd4;
                    end
                end
                if (fz) begin
                    if (got) begin
                        held = 1'b1;
                        held_addr = gaddr;
                    end
                end else if (got) begin
                    model_deliver(gaddr);
                end else if (held) begin
                    model_deliver(held_addr);
                    held = 1'b0;
                end else begin
                    m_valid = 1'b0;
                    m_instr = NOP;
                end
            end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d_valid", c), if_valid, m_valid);
            check($sformatf("rnd%0d_pc", c), if_pc, m_pc);
            check($sformatf("rnd%0d_instr", c), if_instruction, m_instr);
        end

        total++;
        if (delivered < 100) begin
            bad++;
            $display("FAIL progress: delivered %0d words, need at least 100", delivered);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
